axis_fifo_width_conv: RTL and testbench
=======================================

// Module: axis_fifo_width_conv
// PURPOSE
//   AXI4-Stream cycle FIFO with built-in bus-width conversion (LSB lane first).
//   Upsizing is done before the FIFO storage and downsizing after it, so storage is always the wider bus.
//   Sits between MAC/DMA datapaths of different widths to decouple rate and width.
//   Cycle mode only: no frame buffering and no drop features.
// PARAMETERS
//   DEPTH                 4096               FIFO depth in words; cycles = ceil(DEPTH/KEEP_W), rounded up to a power of 2
//   S_DATA_WIDTH          8                  input tdata width
//   S_KEEP_ENABLE         (S_DATA_WIDTH>8)   use s_axis_tkeep; when 0, keep is forced to 1 and the lane count is 1
//   S_KEEP_WIDTH          S_DATA_WIDTH/8     input lanes
//   M_DATA_WIDTH          8                  output tdata width
//   M_KEEP_ENABLE         (M_DATA_WIDTH>8)   drive m_axis_tkeep; when 0, output is all-ones
//   M_KEEP_WIDTH          M_DATA_WIDTH/8     output lanes
//   ID_ENABLE, DEST_ENABLE 0                 propagate tid / tdest; when 0, the output is 0
//   USER_ENABLE           1                  propagate tuser; when 0, the output is 0
//   ID_WIDTH, DEST_WIDTH  8                  sideband widths
//   USER_WIDTH            1                  tuser width
//   USER_BAD_FRAME_VALUE  1'b1               tuser value that marks a bad frame
//   USER_BAD_FRAME_MASK   1'b1               tuser bits compared against the bad-frame value
//   Elaboration error if lane sizes are unequal (S_DATA_WIDTH/S_KEEP_W != M_DATA_WIDTH/M_KEEP_W).
//   Elaboration error if either data width is not divisible by its lane count.
// PORTS
//   Single clock domain. Reset is synchronous and active-high.
//   clk                in   1       clock
//   rst                in   1       synchronous active-high reset
//   s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser   in (tready out)   S_DATA_WIDTH, S_KEEP_WIDTH, 1, 1, 1, ID, DEST, USER    input stream
//   m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser   out (tready in)   M_DATA_WIDTH, M_KEEP_WIDTH, 1, 1, 1, ID, DEST, USER    output stream
//   status_overflow    out  1       always 0 (no drop in cycle mode)
//   status_bad_frame   out  1       1-cycle pulse: tlast beat written with (tuser & MASK) == (VALUE & MASK)
//   status_good_frame  out  1       1-cycle pulse: any other tlast beat written
// BEHAVIOUR
//   Reset:
//     - FIFO emptied; m_axis_tvalid = 0; status outputs = 0.
//     - Adapter partial-word state cleared; s_axis_tready returns 1 the cycle after reset deasserts.
//     - Mid-frame reset discards all held data; there is no tlast recovery.
//   Handshake: transfer when tvalid & tready. m_axis outputs are held stable while tvalid=1 and tready=0.
//   Storage:
//     - Dual-pointer RAM with one extra pointer bit; full when the pointers differ only in the MSB.
//     - s-side tready (FIFO side) = !full. Simultaneous read and write when full or empty is legal.
//     - Registered output stage; for equal widths, the first beat is valid 2 cycles after input acceptance.
//     - Full throughput of 1 beat per cycle is sustained.
//   Upsize (M lanes = N x S lanes):
//     - Pack segments LSB-first into an M word.
//     - Push to the FIFO when N segments are collected or tlast is seen.
//     - On early tlast, unfilled lanes get tkeep=0 and tdata=0.
//     - tid/tdest come from the last segment; tuser is the OR of all segments.
//     - Input tready drops only while a completed word waits for the FIFO.
//   Downsize (S lanes = N x M lanes):
//     - Emit segments LSB-first from each FIFO word.
//     - Skip trailing segments whose tkeep is all zero.
//     - tlast goes on the final non-empty segment of a tlast word.
//     - tid/tdest/tuser are replicated on every segment.
//   Equal widths: adapter bypassed; pure FIFO.
// TESTING
//   - Equal 8/8 widths: write 0x01..0x04 with tlast on 0x04, m_axis_tready=1.
//     Expect the same 4 bytes in order, tlast on 0x04, one good_frame pulse.
//   - Upsize 8->32: bytes 11,22,33,44,55 with tlast on 55.
//     Expect word 0x44332211 keep=F, then 0x00000055 keep=1 with tlast.
//   - Downsize 32->8: word 0x44332211 keep=0111 with tlast.
//     Expect bytes 11,22,33 with tlast on 33 only.
//   - Fill DEPTH=16 at 8/8 with m_axis_tready=0: s_axis_tready=0 after 16 beats.
//     One pop then restores tready; no data loss or reorder.
//   - tuser=1 on a tlast beat: status_bad_frame pulses for 1 cycle, status_good_frame stays 0.
//   - Assert rst mid-frame: m_axis_tvalid=0 the next cycle.
//     A new frame then passes unchanged, with no leftover partial words.

Source files
------------

// File: rtl/axis_fifo_width_conv.sv
// AXI4-Stream cycle FIFO with LSB-lane-first width conversion.
// Upsizing packs before storage and downsizing unpacks after it, so the RAM is always the wide bus.
module axis_fifo_width_conv #(
  parameter int DEPTH         = 4096,
  parameter int S_DATA_WIDTH  = 8,
  parameter bit S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
  parameter int S_KEEP_WIDTH  = S_DATA_WIDTH / 8,
  parameter int M_DATA_WIDTH  = 8,
  parameter bit M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
  parameter int M_KEEP_WIDTH  = M_DATA_WIDTH / 8,
  parameter bit ID_ENABLE     = 1'b0,
  parameter bit DEST_ENABLE   = 1'b0,
  parameter bit USER_ENABLE   = 1'b1,
  parameter int ID_WIDTH      = 8,
  parameter int DEST_WIDTH    = 8,
  parameter int USER_WIDTH    = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1),
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_MASK  = USER_WIDTH'(1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [ID_WIDTH-1:0]     s_axis_tid,
  input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [ID_WIDTH-1:0]     m_axis_tid,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic                    status_overflow,
  output logic                    status_bad_frame,
  output logic                    status_good_frame
);

  localparam int unsigned SK     = S_KEEP_ENABLE ? S_KEEP_WIDTH : 1;
  localparam int unsigned MK     = M_KEEP_ENABLE ? M_KEEP_WIDTH : 1;
  localparam int unsigned LANE_W = S_DATA_WIDTH / SK;
  localparam int unsigned KW     = (SK > MK) ? SK : MK;
  localparam int unsigned DW     = KW * LANE_W;
  localparam int unsigned CYCLES = (DEPTH + KW - 1) / KW;
  localparam int unsigned AW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned WORD_W = DW + KW + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;

  if ((S_DATA_WIDTH % SK) != 0 || (M_DATA_WIDTH % MK) != 0) begin : g_err_div
    $error("data width not divisible by lane count");
  end
  if ((S_DATA_WIDTH / SK) != (M_DATA_WIDTH / MK)) begin : g_err_lane
    $error("input and output lane sizes differ");
  end
  if ((KW % SK) != 0 || (KW % MK) != 0) begin : g_err_ratio
    $error("lane counts are not integer multiples");
  end

  // Sideband/keep as seen by the storage path (disabled fields read as zero / all-ones)
  logic [SK-1:0]         s_keep_eff;
  logic [ID_WIDTH-1:0]   s_id;
  logic [DEST_WIDTH-1:0] s_dest;
  logic [USER_WIDTH-1:0] s_user;

  if (S_KEEP_ENABLE) begin : g_skeep
    assign s_keep_eff = SK'(s_axis_tkeep);
  end else begin : g_skeep_off
    assign s_keep_eff = '1;
  end
  assign s_id   = ID_ENABLE   ? s_axis_tid   : '0;
  assign s_dest = DEST_ENABLE ? s_axis_tdest : '0;
  assign s_user = USER_ENABLE ? s_axis_tuser : '0;

  // FIFO write side
  logic [DW-1:0]         fin_data;
  logic [KW-1:0]         fin_keep;
  logic                  fin_last, fin_valid;
  logic [ID_WIDTH-1:0]   fin_id;
  logic [DEST_WIDTH-1:0] fin_dest;
  logic [USER_WIDTH-1:0] fin_user;
  logic                  fifo_ready_q;

  // FIFO read side (second output register)
  logic [DW-1:0]         out_data;
  logic [KW-1:0]         out_keep;
  logic                  out_last, out_valid, fout_ready;
  logic [ID_WIDTH-1:0]   out_id;
  logic [DEST_WIDTH-1:0] out_dest;
  logic [USER_WIDTH-1:0] out_user;

  logic [WORD_W-1:0] mem [0:(1 << AW)-1];
  logic [WORD_W-1:0] s1_word, out_word;
  logic              s1_valid;
  logic [PW-1:0]     wr_ptr, rd_ptr, rel_ptr, wr_ptr_n, rel_ptr_n;
  logic              wr_en, fetch, s2_load, pop, empty, full_n;

  // rel_ptr trails rd_ptr until the word leaves the output register, so held words still count
  always_comb begin
    wr_en     = fin_valid && fifo_ready_q;
    pop       = out_valid && fout_ready;
    s2_load   = s1_valid && (!out_valid || fout_ready);
    empty     = (wr_ptr == rd_ptr);
    fetch     = !empty && (!s1_valid || s2_load);
    wr_ptr_n  = wr_ptr + PW'(wr_en);
    rel_ptr_n = rel_ptr + PW'(pop);
    full_n    = (wr_ptr_n == {~rel_ptr_n[AW], rel_ptr_n[AW-1:0]});
  end

  // Storage RAM write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {fin_data, fin_keep, fin_last, fin_id, fin_dest, fin_user};
  end

  // Registered RAM read and output data stage
  always_ff @(posedge clk) begin
    if (fetch)   s1_word  <= mem[rd_ptr[AW-1:0]];
    if (s2_load) out_word <= s1_word;
  end

  // Pointers, pipeline valids, input ready and frame status
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      rel_ptr           <= '0;
      s1_valid          <= 1'b0;
      out_valid         <= 1'b0;
      fifo_ready_q      <= 1'b0;
      status_bad_frame  <= 1'b0;
      status_good_frame <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rel_ptr      <= rel_ptr_n;
      fifo_ready_q <= !full_n;
      if (fetch) rd_ptr <= rd_ptr + PW'(1);
      if (fetch) s1_valid <= 1'b1;
      else if (s2_load) s1_valid <= 1'b0;
      if (s2_load) out_valid <= 1'b1;
      else if (pop) out_valid <= 1'b0;
      status_bad_frame  <= wr_en && fin_last &&
                           ((fin_user & USER_BAD_FRAME_MASK) == (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
      status_good_frame <= wr_en && fin_last &&
                           ((fin_user & USER_BAD_FRAME_MASK) != (USER_BAD_FRAME_VALUE & USER_BAD_FRAME_MASK));
    end
  end

  assign {out_data, out_keep, out_last, out_id, out_dest, out_user} = out_word;
  assign status_overflow = 1'b0;

  if (MK > SK) begin : g_up
    localparam int unsigned N  = MK / SK;
    localparam int unsigned CW = $clog2(N);
    logic [DW-1:0]         up_data, up_data_n;
    logic [KW-1:0]         up_keep, up_keep_n;
    logic [USER_WIDTH-1:0] up_user, up_user_n;
    logic [ID_WIDTH-1:0]   up_id;
    logic [DEST_WIDTH-1:0] up_dest;
    logic                  up_last, up_valid, accept;
    logic [CW-1:0]         up_cnt;

    assign s_axis_tready = !up_valid || fifo_ready_q;
    assign accept        = s_axis_tvalid && s_axis_tready;

    // Merge the incoming segment into the word under construction (fresh word when count is zero)
    always_comb begin
      up_data_n = (up_cnt == '0) ? '0 : up_data;
      up_keep_n = (up_cnt == '0) ? '0 : up_keep;
      up_user_n = (up_cnt == '0) ? '0 : up_user;
      up_data_n = up_data_n | (DW'(s_axis_tdata) << (32'(up_cnt) * S_DATA_WIDTH));
      up_keep_n = up_keep_n | (KW'(s_keep_eff) << (32'(up_cnt) * SK));
      up_user_n = up_user_n | s_user;
    end

    // Segment packer; a completed word waits in place until the FIFO takes it
    always_ff @(posedge clk) begin
      if (rst) begin
        up_valid <= 1'b0;
        up_cnt   <= '0;
        up_data  <= '0;
        up_keep  <= '0;
        up_user  <= '0;
        up_id    <= '0;
        up_dest  <= '0;
        up_last  <= 1'b0;
      end else begin
        if (up_valid && fifo_ready_q) up_valid <= 1'b0;
        if (accept) begin
          up_data <= up_data_n;
          up_keep <= up_keep_n;
          up_user <= up_user_n;
          up_id   <= s_id;
          up_dest <= s_dest;
          up_last <= s_axis_tlast;
          if (s_axis_tlast || up_cnt == CW'(N - 1)) begin
            up_valid <= 1'b1;
            up_cnt   <= '0;
          end else begin
            up_cnt <= up_cnt + CW'(1);
          end
        end
      end
    end

    assign fin_valid = up_valid;
    assign fin_data  = up_data;
    assign fin_keep  = up_keep;
    assign fin_last  = up_last;
    assign fin_id    = up_id;
    assign fin_dest  = up_dest;
    assign fin_user  = up_user;
  end else begin : g_in_direct
    assign s_axis_tready = fifo_ready_q;
    assign fin_valid     = s_axis_tvalid;
    assign fin_data      = DW'(s_axis_tdata);
    assign fin_keep      = KW'(s_keep_eff);
    assign fin_last      = s_axis_tlast;
    assign fin_id        = s_id;
    assign fin_dest      = s_dest;
    assign fin_user      = s_user;
  end

  if (SK > MK) begin : g_dn
    logic [DW-1:0]         dn_data;
    logic [KW-1:0]         dn_keep, rem_keep;
    logic                  dn_valid, dn_last_word, dn_seg_last;
    logic [ID_WIDTH-1:0]   dn_id;
    logic [DEST_WIDTH-1:0] dn_dest;
    logic [USER_WIDTH-1:0] dn_user;

    assign rem_keep   = dn_keep >> MK;
    assign fout_ready = !dn_valid || (m_axis_tready && rem_keep == '0);

    // Segment shifter: load a word, then step LSB-first until no kept lanes remain
    always_ff @(posedge clk) begin
      if (rst) begin
        dn_valid     <= 1'b0;
        dn_data      <= '0;
        dn_keep      <= '0;
        dn_last_word <= 1'b0;
        dn_seg_last  <= 1'b0;
        dn_id        <= '0;
        dn_dest      <= '0;
        dn_user      <= '0;
      end else if (out_valid && fout_ready) begin
        dn_valid     <= 1'b1;
        dn_data      <= out_data;
        dn_keep      <= out_keep;
        dn_last_word <= out_last;
        dn_seg_last  <= out_last && ((out_keep >> MK) == '0);
        dn_id        <= out_id;
        dn_dest      <= out_dest;
        dn_user      <= out_user;
      end else if (dn_valid && m_axis_tready) begin
        if (rem_keep == '0) begin
          dn_valid <= 1'b0;
        end else begin
          dn_data     <= dn_data >> M_DATA_WIDTH;
          dn_keep     <= rem_keep;
          dn_seg_last <= dn_last_word && ((rem_keep >> MK) == '0);
        end
      end
    end

    assign m_axis_tvalid = dn_valid;
    assign m_axis_tdata  = dn_data[M_DATA_WIDTH-1:0];
    assign m_axis_tlast  = dn_seg_last;
    assign m_axis_tid    = dn_id;
    assign m_axis_tdest  = dn_dest;
    assign m_axis_tuser  = dn_user;
    if (M_KEEP_ENABLE) begin : g_mkeep
      assign m_axis_tkeep = M_KEEP_WIDTH'(dn_keep[MK-1:0]);
    end else begin : g_mkeep_off
      assign m_axis_tkeep = '1;
    end
  end else begin : g_out_direct
    assign fout_ready    = m_axis_tready;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = M_DATA_WIDTH'(out_data);
    assign m_axis_tlast  = out_last;
    assign m_axis_tid    = out_id;
    assign m_axis_tdest  = out_dest;
    assign m_axis_tuser  = out_user;
    if (M_KEEP_ENABLE) begin : g_mkeep
      assign m_axis_tkeep = M_KEEP_WIDTH'(out_keep);
    end else begin : g_mkeep_off
      assign m_axis_tkeep = '1;
    end
  end

  // Inputs that some parameter sets leave unread
  logic unused_sink;
  assign unused_sink = ^{s_axis_tkeep, out_keep};

endmodule

// File: tb/tb_axis_fifo_width_conv.sv
// Scoreboard bench for axis_fifo_width_conv: 8/8 (DEPTH 16), 8->32 upsize and 32->8 downsize.
module tb_axis_fifo_width_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } exp_t;

  exp_t q_eq[$], q_up[$], q_dn[$];
  exp_t x_eq, x_up, x_dn;
  int errors = 0;
  int checks = 0;
  int eq_good = 0, eq_bad = 0, up_good = 0, up_bad = 0, dn_good = 0, dn_bad = 0;

  // 8/8 instance
  logic [7:0] eq_s_data, eq_m_data, eq_m_id, eq_m_dest;
  logic [0:0] eq_m_keep;
  logic eq_s_valid = 0, eq_s_ready, eq_s_last = 0, eq_s_user = 0;
  logic eq_m_valid, eq_m_ready = 1, eq_m_last, eq_m_user, eq_ovf, eq_bad_p, eq_good_p;
  // 8->32 instance
  logic [7:0]  up_s_data, up_m_id, up_m_dest;
  logic [31:0] up_m_data;
  logic [3:0]  up_m_keep;
  logic up_s_valid = 0, up_s_ready, up_s_last = 0, up_s_user = 0;
  logic up_m_valid, up_m_ready = 1, up_m_last, up_m_user, up_ovf, up_bad_p, up_good_p;
  // 32->8 instance
  logic [31:0] dn_s_data;
  logic [3:0]  dn_s_keep;
  logic [7:0]  dn_m_data, dn_m_id, dn_m_dest;
  logic [0:0]  dn_m_keep;
  logic dn_s_valid = 0, dn_s_ready, dn_s_last = 0, dn_s_user = 0;
  logic dn_m_valid, dn_m_ready = 1, dn_m_last, dn_m_user, dn_ovf, dn_bad_p, dn_good_p;

  axis_fifo_width_conv #(.DEPTH(16), .S_DATA_WIDTH(8), .M_DATA_WIDTH(8)) dut_eq (
    .clk(clk), .rst(rst),
    .s_axis_tdata(eq_s_data), .s_axis_tkeep(1'b1), .s_axis_tvalid(eq_s_valid), .s_axis_tready(eq_s_ready),
    .s_axis_tlast(eq_s_last), .s_axis_tid(8'h00), .s_axis_tdest(8'h00), .s_axis_tuser(eq_s_user),
    .m_axis_tdata(eq_m_data), .m_axis_tkeep(eq_m_keep), .m_axis_tvalid(eq_m_valid), .m_axis_tready(eq_m_ready),
    .m_axis_tlast(eq_m_last), .m_axis_tid(eq_m_id), .m_axis_tdest(eq_m_dest), .m_axis_tuser(eq_m_user),
    .status_overflow(eq_ovf), .status_bad_frame(eq_bad_p), .status_good_frame(eq_good_p));

  axis_fifo_width_conv #(.DEPTH(64), .S_DATA_WIDTH(8), .M_DATA_WIDTH(32)) dut_up (
    .clk(clk), .rst(rst),
    .s_axis_tdata(up_s_data), .s_axis_tkeep(1'b1), .s_axis_tvalid(up_s_valid), .s_axis_tready(up_s_ready),
    .s_axis_tlast(up_s_last), .s_axis_tid(8'h00), .s_axis_tdest(8'h00), .s_axis_tuser(up_s_user),
    .m_axis_tdata(up_m_data), .m_axis_tkeep(up_m_keep), .m_axis_tvalid(up_m_valid), .m_axis_tready(up_m_ready),
    .m_axis_tlast(up_m_last), .m_axis_tid(up_m_id), .m_axis_tdest(up_m_dest), .m_axis_tuser(up_m_user),
    .status_overflow(up_ovf), .status_bad_frame(up_bad_p), .status_good_frame(up_good_p));

  axis_fifo_width_conv #(.DEPTH(64), .S_DATA_WIDTH(32), .M_DATA_WIDTH(8)) dut_dn (
    .clk(clk), .rst(rst),
    .s_axis_tdata(dn_s_data), .s_axis_tkeep(dn_s_keep), .s_axis_tvalid(dn_s_valid), .s_axis_tready(dn_s_ready),
    .s_axis_tlast(dn_s_last), .s_axis_tid(8'h00), .s_axis_tdest(8'h00), .s_axis_tuser(dn_s_user),
    .m_axis_tdata(dn_m_data), .m_axis_tkeep(dn_m_keep), .m_axis_tvalid(dn_m_valid), .m_axis_tready(dn_m_ready),
    .m_axis_tlast(dn_m_last), .m_axis_tid(dn_m_id), .m_axis_tdest(dn_m_dest), .m_axis_tuser(dn_m_user),
    .status_overflow(dn_ovf), .status_bad_frame(dn_bad_p), .status_good_frame(dn_good_p));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitors: pop the scoreboard on every output handshake; also count status pulse cycles
  always @(negedge clk) begin
    if (!rst && eq_m_valid && eq_m_ready) begin
      if (q_eq.size() == 0) chk("eq_unexpected_beat", {eq_m_data, eq_m_last}, 0);
      else begin
        x_eq = q_eq.pop_front();
        chk("eq_beat", {eq_m_data, eq_m_keep, eq_m_last, eq_m_user},
            {x_eq.data[7:0], x_eq.keep[0], x_eq.last, x_eq.user});
      end
    end
    if (!rst && up_m_valid && up_m_ready) begin
      if (q_up.size() == 0) chk("up_unexpected_beat", {up_m_data, up_m_last}, 0);
      else begin
        x_up = q_up.pop_front();
        chk("up_word", {up_m_data, up_m_keep, up_m_last, up_m_user},
            {x_up.data, x_up.keep, x_up.last, x_up.user});
      end
    end
    if (!rst && dn_m_valid && dn_m_ready) begin
      if (q_dn.size() == 0) chk("dn_unexpected_beat", {dn_m_data, dn_m_last}, 0);
      else begin
        x_dn = q_dn.pop_front();
        chk("dn_byte", {dn_m_data, dn_m_keep, dn_m_last, dn_m_user},
            {x_dn.data[7:0], x_dn.keep[0], x_dn.last, x_dn.user});
      end
    end
    if (!rst) begin
      if (eq_good_p) eq_good++;
      if (eq_bad_p)  eq_bad++;
      if (up_good_p) up_good++;
      if (up_bad_p)  up_bad++;
      if (dn_good_p) dn_good++;
      if (dn_bad_p)  dn_bad++;
    end
  end

  // Each send starts and ends just after a rising edge; tready is sampled mid-cycle
  task automatic send_eq(input logic [7:0] d, input logic l, input logic u);
    bit done = 0;
    eq_s_data = d; eq_s_last = l; eq_s_user = u; eq_s_valid = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk); done = eq_s_ready;
      @(posedge clk); #1;
    end
    eq_s_valid = 0;
    if (!done) chk("eq_send_timeout", 0, 1);
  endtask

  task automatic send_up(input logic [7:0] d, input logic l, input logic u);
    bit done = 0;
    up_s_data = d; up_s_last = l; up_s_user = u; up_s_valid = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk); done = up_s_ready;
      @(posedge clk); #1;
    end
    up_s_valid = 0;
    if (!done) chk("up_send_timeout", 0, 1);
  endtask

  task automatic send_dn(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    bit done = 0;
    dn_s_data = d; dn_s_keep = k; dn_s_last = l; dn_s_user = u; dn_s_valid = 1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk); done = dn_s_ready;
      @(posedge clk); #1;
    end
    dn_s_valid = 0;
    if (!done) chk("dn_send_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (q_eq.size() == 0 && q_up.size() == 0 && q_dn.size() == 0);
    end
    chk(name, ok, 1);
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    eq_s_data = 0; up_s_data = 0; dn_s_data = 0; dn_s_keep = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("eq_m_valid_in_reset", eq_m_valid, 0);
    chk("up_m_valid_in_reset", up_m_valid, 0);
    chk("dn_m_valid_in_reset", dn_m_valid, 0);
    chk("eq_status_in_reset", {eq_ovf, eq_bad_p, eq_good_p}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("eq_s_ready_after_reset", eq_s_ready, 1);
    chk("up_s_ready_after_reset", up_s_ready, 1);
    chk("dn_s_ready_after_reset", dn_s_ready, 1);

    // Equal widths: 01..04, tlast on 04
    for (int i = 1; i <= 4; i++) begin
      q_eq.push_back('{32'(i), 4'h1, (i == 4), 1'b0});
      send_eq(8'(i), (i == 4), 1'b0);
    end
    drain("eq_frame_drain");
    chk("eq_good_after_frame", eq_good, 1);
    chk("eq_bad_after_frame", eq_bad, 0);

    // Upsize: 11..55 -> 44332211/F, 00000055/1 last; then user OR across segments
    q_up.push_back('{32'h44332211, 4'hF, 1'b0, 1'b0});
    q_up.push_back('{32'h00000055, 4'h1, 1'b1, 1'b0});
    send_up(8'h11, 0, 0); send_up(8'h22, 0, 0); send_up(8'h33, 0, 0);
    send_up(8'h44, 0, 0); send_up(8'h55, 1, 0);
    q_up.push_back('{32'h0000B2A1, 4'h3, 1'b1, 1'b1});
    send_up(8'hA1, 0, 1); send_up(8'hB2, 1, 0);
    drain("up_drain");
    chk("up_good_count", up_good, 1);
    chk("up_bad_count", up_bad, 1);

    // Downsize: 44332211 keep 0111 last (user replicated), then full word + 1-lane tail
    q_dn.push_back('{32'h11, 4'h1, 1'b0, 1'b1});
    q_dn.push_back('{32'h22, 4'h1, 1'b0, 1'b1});
    q_dn.push_back('{32'h33, 4'h1, 1'b1, 1'b1});
    send_dn(32'h44332211, 4'b0111, 1, 1);
    q_dn.push_back('{32'hAA, 4'h1, 1'b0, 1'b0});
    q_dn.push_back('{32'hBB, 4'h1, 1'b0, 1'b0});
    q_dn.push_back('{32'hCC, 4'h1, 1'b0, 1'b0});
    q_dn.push_back('{32'hDD, 4'h1, 1'b0, 1'b0});
    q_dn.push_back('{32'h99, 4'h1, 1'b1, 1'b0});
    send_dn(32'hDDCCBBAA, 4'hF, 0, 0);
    send_dn(32'h00000099, 4'h1, 1, 0);
    drain("dn_drain");
    chk("dn_bad_count", dn_bad, 1);
    chk("dn_good_count", dn_good, 1);

    // Fill 16 entries with output stalled, pop one, add one, then drain all in order
    eq_m_ready = 0;
    for (int i = 0; i < 16; i++) begin
      q_eq.push_back('{32'(8'h10 + i), 4'h1, (i == 15), 1'b0});
      send_eq(8'(8'h10 + i), (i == 15), 1'b0);
    end
    chk("eq_ready_low_when_full", eq_s_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("eq_ready_stays_low_full", eq_s_ready, 0);
    eq_m_ready = 1;
    @(posedge clk); #1;
    eq_m_ready = 0;
    chk("eq_ready_after_one_pop", eq_s_ready, 1);
    q_eq.push_back('{32'h20, 4'h1, 1'b1, 1'b0});
    send_eq(8'h20, 1, 0);
    eq_m_ready = 1;
    drain("eq_fill_drain");
    chk("eq_good_after_fill", eq_good, 3);

    // Bad frame marker on tlast beat
    q_eq.push_back('{32'h5A, 4'h1, 1'b1, 1'b1});
    send_eq(8'h5A, 1, 1);
    drain("eq_bad_drain");
    chk("eq_bad_pulse_count", eq_bad, 1);
    chk("eq_good_unchanged", eq_good, 3);

    // Mid-frame reset: held and partial data must vanish
    eq_m_ready = 0; dn_m_ready = 0;
    send_eq(8'h61, 0, 0); send_eq(8'h62, 0, 0);
    send_up(8'hC1, 0, 0); send_up(8'hC2, 0, 0);
    send_dn(32'h01020304, 4'hF, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("eq_valid_before_reset", eq_m_valid, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("eq_valid_after_reset", eq_m_valid, 0);
    chk("up_valid_after_reset", up_m_valid, 0);
    chk("dn_valid_after_reset", dn_m_valid, 0);
    rst = 0;
    @(posedge clk); #1;
    eq_m_ready = 1; up_m_ready = 1; dn_m_ready = 1;
    q_up.push_back('{32'h00030201, 4'h7, 1'b1, 1'b0});
    send_up(8'h01, 0, 0); send_up(8'h02, 0, 0); send_up(8'h03, 1, 0);
    q_eq.push_back('{32'h77, 4'h1, 1'b1, 1'b0});
    send_eq(8'h77, 1, 0);
    q_dn.push_back('{32'hEF, 4'h1, 1'b0, 1'b0});
    q_dn.push_back('{32'hBE, 4'h1, 1'b1, 1'b0});
    send_dn(32'h0000BEEF, 4'b0011, 1, 0);
    drain("post_reset_drain");
    chk("overflow_never", {eq_ovf, up_ovf, dn_ovf}, 0);

    repeat (10) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
